id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage RV32 core, with integrated load-use hazard detection.
- Captures decoded operands and control from ID and presents them registered to EX.
- EX feeds the forwarding unit (ex_rs1/ex_rs2) and the ALU.
- Inserts bubbles on load-use hazards, clears on branch flush, holds on external stall.
- Counts inserted load-use bubbles.

Parameters:
- XLEN, 32, datapath width (pc, operands, immediate).
- CTRL_W, 8, control bundle width. Bit map: [0] regwrite, [1] memread, [2] memwrite, [3] memtoreg, [4] branch, [5] jump, [6] alusrc, [7] opaque pass-through.
- CNT_W, 16, width of the load-use bubble counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rdata1, id_rdata2  in  XLEN  register-file read data
- id_imm  in  XLEN  immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct  in  4  {funct7[5], funct3}
- id_ctrl  in  CTRL_W  control bundle
- flush_i  in  1  branch/jump taken (from EX/MEM); kill ID/EX contents
- ext_stall_i  in  1  whole-pipeline freeze (memory not ready)
- wb_regwrite  in  1  WB write enable (used only with the bypass option)
- wb_rd  in  5  WB destination (used only with the bypass option)
- wb_wdata  in  XLEN  WB write data (used only with the bypass option)
- ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, ex_ctrl  out  widths as inputs  registered EX-stage fields
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- ldu_bubble_cnt  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- All outputs registered except stall_o. Latency ID→EX is 1 cycle.
- Reset (async, on rst high): every registered output is 0. ex_valid=0, ex_ctrl=0, ex_rs1=ex_rs2=ex_rd=0, ldu_bubble_cnt=0. Reset mid-operation discards all in-flight contents immediately.
- Hazard:
  - hz = ex_valid & ex_ctrl[1] & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
  - Compare rs2 unconditionally; no opcode-based masking.
- stall_o = hz & ~flush_i. stall_o is independent of ext_stall_i; upstream ORs the two.
- Per-edge update priority (first match wins):
  1. flush_i=1 → load bubble.
  2. ext_stall_i=1 → hold all registers, counter unchanged.
  3. hz=1 → load bubble; ldu_bubble_cnt += 1, saturating at all-ones.
  4. else → load all id_* fields; ex_valid=id_valid.
- Bubble definition: ex_valid=0, ex_ctrl=0, ex_rs1=ex_rs2=ex_rd=0, so the forwarding unit sees no match. Data fields (pc, rdata, imm, funct) may be loaded or held; they are don't-care.
- id_valid=0 with no hazard: load as in rule 4. Mandatory: if id_valid=0 then ex_ctrl is forced to 0.
- Simultaneous cases:
  - flush with hazard → bubble, counter not incremented, stall_o=0.
  - ext_stall with hazard → hold, stall_o=1, counter not incremented.
- The hazard resolves after one bubble: the load advances and ex_valid=0, so hz drops.
- Back-to-back loads each trigger an independent check.

Optional Feature:
- Macro: IDEX_RF_BYPASS_EN.
- Defined: on load (rule 4), if wb_regwrite & (wb_rd!=0) & (wb_rd==id_rs1), ex_rdata1 takes wb_wdata instead of id_rdata1. Same rule for rs2/ex_rdata2. Covers a register file without write-before-read.
- Undefined: wb_* ports exist but are ignored; ex_rdata* always take id_rdata*.

Test Plan:
- rst asserted mid-stream with ex_valid=1 → all outputs 0 asynchronously, before the next edge; ldu_bubble_cnt=0.
- EX holds lw x5 (ctrl[1]=1, rd=5), ID holds add x6,x5,x7 → stall_o=1; next edge ex_valid=0, ex_ctrl=0, ex_rd=0, cnt=1; following edge add loads with ex_rs1=5.
- Same hazard with flush_i=1 → stall_o=0; next edge bubble; cnt unchanged.
- ext_stall_i=1 for 3 cycles with ex_pc=0x100 loaded → ex_* unchanged for 3 edges; load of 0x104 on the first edge after release.
- Load with rd=x0 followed by a use of x0 → no stall; ldu_bubble_cnt at 0xFFFF plus another hazard → stays 0xFFFF.
- IDEX_RF_BYPASS_EN defined, wb_rd=3, wb_wdata=0xDEADBEEF, id_rs2=3, id_rdata2=0x11 → ex_rdata2=0xDEADBEEF. Macro undefined → 0x11.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and bubble counter.
// Optional IDEX_RF_BYPASS_EN: forward the WB write into ex_rdata1/ex_rdata2 on load.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [3:0]        id_funct,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush_i,
    input  logic              ext_stall_i,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_wdata,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rdata1,
    output logic [XLEN-1:0]   ex_rdata2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [3:0]        ex_funct,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_o,
    output logic [CNT_W-1:0]  ldu_bubble_cnt
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [3:0]        funct_q, funct_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hz;
    logic [XLEN-1:0]   src1, src2;

`ifdef IDEX_RF_BYPASS_EN
    // Register file without write-before-read: take the value being written this cycle.
    assign src1 = (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_wdata : id_rdata1;
    assign src2 = (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_wdata : id_rdata2;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_regwrite, wb_rd, wb_wdata};
    assign src1 = id_rdata1;
    assign src2 = id_rdata2;
`endif

    assign hz      = valid_q & ctrl_q[1] & (rd_q != 5'd0) & id_valid
                   & ((rd_q == id_rs1) | (rd_q == id_rs2));
    assign stall_o = hz & ~flush_i;

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        funct_d  = funct_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        if (flush_i || (!ext_stall_i && hz)) begin
            // Bubble: data fields are held, only what forwarding/hazard logic sees is cleared.
            valid_d = 1'b0;
            ctrl_d  = '0;
            rs1_d   = 5'd0;
            rs2_d   = 5'd0;
            rd_d    = 5'd0;
            if (!flush_i && cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!ext_stall_i) begin
            valid_d  = id_valid;
            pc_d     = id_pc;
            rdata1_d = src1;
            rdata2_d = src2;
            imm_d    = id_imm;
            rs1_d    = id_rs1;
            rs2_d    = id_rs2;
            rd_d     = id_rd;
            funct_d  = id_funct;
            ctrl_d   = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            rd_q     <= 5'd0;
            funct_q  <= 4'd0;
            ctrl_q   <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            funct_q  <= funct_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_pc          = pc_q;
    assign ex_rdata1      = rdata1_q;
    assign ex_rdata2      = rdata2_q;
    assign ex_imm         = imm_q;
    assign ex_rs1         = rs1_q;
    assign ex_rs2         = rs2_q;
    assign ex_rd          = rd_q;
    assign ex_funct       = funct_q;
    assign ex_ctrl        = ctrl_q;
    assign ldu_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid = 1'b0;
    logic [XLEN-1:0] id_pc = '0, id_rdata1 = '0, id_rdata2 = '0, id_imm = '0, wb_wdata = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
    logic [3:0] id_funct = '0;
    logic [CTRL_W-1:0] id_ctrl = '0;
    logic flush_i = 1'b0, ext_stall_i = 1'b0, wb_regwrite = 1'b0;

    logic ex_valid, stall_o;
    logic [XLEN-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0] ex_funct;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0] ldu_bubble_cnt;

    int n_checks = 0;
    int n_fail = 0;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_ctrl(id_ctrl), .flush_i(flush_i), .ext_stall_i(ext_stall_i),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .ex_ctrl(ex_ctrl), .stall_o(stall_o),
        .ldu_bubble_cnt(ldu_bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what EX must hold, derived from the rules on the ID inputs.
    logic m_valid, m_known;
    logic [XLEN-1:0] m_pc, m_r1, m_r2, m_imm;
    logic [4:0] m_rs1, m_rs2, m_rd;
    logic [3:0] m_funct;
    logic [CTRL_W-1:0] m_ctrl;
    int m_cnt;

    function automatic logic model_hz();
        return m_valid && m_ctrl[1] && m_rd != 0 && id_valid && (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    function automatic logic [XLEN-1:0] model_src(input logic [4:0] rs, input logic [XLEN-1:0] rf);
`ifdef IDEX_RF_BYPASS_EN
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return wb_wdata;
`endif
        return rf;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 0; m_known <= 1; m_pc <= 0; m_r1 <= 0; m_r2 <= 0; m_imm <= 0;
            m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_funct <= 0; m_ctrl <= 0; m_cnt <= 0;
        end else if (flush_i || (!ext_stall_i && model_hz())) begin
            m_valid <= 0; m_ctrl <= 0; m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_known <= 0;
            if (!flush_i) m_cnt <= (m_cnt == int'(CNT_MAX)) ? m_cnt : m_cnt + 1;
        end else if (!ext_stall_i) begin
            m_valid <= id_valid; m_known <= 1; m_pc <= id_pc;
            m_r1 <= model_src(id_rs1, id_rdata1); m_r2 <= model_src(id_rs2, id_rdata2);
            m_imm <= id_imm; m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd;
            m_funct <= id_funct; m_ctrl <= id_valid ? id_ctrl : '0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ex_valid", 32'(ex_valid), 32'(m_valid));
            chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
            chk("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
            chk("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
            chk("ex_rd", 32'(ex_rd), 32'(m_rd));
            chk("cnt", 32'(ldu_bubble_cnt), 32'(m_cnt));
            chk("stall_o", 32'(stall_o), 32'(model_hz() && !flush_i));
            if (m_known) begin
                chk("ex_pc", ex_pc, m_pc);
                chk("ex_rdata1", ex_rdata1, m_r1);
                chk("ex_rdata2", ex_rdata2, m_r2);
                chk("ex_imm", ex_imm, m_imm);
                chk("ex_funct", 32'(ex_funct), 32'(m_funct));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_pc = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct = 0; id_ctrl = 0;
        flush_i = 0; ext_stall_i = 0; wb_regwrite = 0; wb_rd = 0; wb_wdata = 0;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [CTRL_W-1:0] ctrl, input logic [XLEN-1:0] pc);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl; id_pc = pc;
        id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom; id_funct = 4'($urandom);
    endtask

    initial begin
        idle();
        #12 rst = 0;
        #1;
        chk("reset ex_valid", 32'(ex_valid), 0);
        chk("reset cnt", 32'(ldu_bubble_cnt), 0);
        step();

        // lw x5 then add x6,x5,x7
        drive(5'd1, 5'd0, 5'd5, 8'h0B, 32'h40);
        step();
        drive(5'd5, 5'd7, 5'd6, 8'h01, 32'h44);
        #1 chk("lu stall_o", 32'(stall_o), 1);
        step();
        chk("lu bubble valid", 32'(ex_valid), 0);
        chk("lu bubble rd", 32'(ex_rd), 0);
        chk("lu cnt", 32'(ldu_bubble_cnt), 1);
        chk("lu resolved stall", 32'(stall_o), 0);
        step();
        chk("add rs1", 32'(ex_rs1), 5);
        chk("add valid", 32'(ex_valid), 1);

        // same hazard under flush
        drive(5'd1, 5'd0, 5'd5, 8'h0B, 32'h48);
        step();
        drive(5'd5, 5'd7, 5'd6, 8'h01, 32'h4C);
        flush_i = 1;
        #1 chk("flush stall_o", 32'(stall_o), 0);
        step();
        chk("flush valid", 32'(ex_valid), 0);
        chk("flush cnt", 32'(ldu_bubble_cnt), 1);
        flush_i = 0;

        // external stall hold
        drive(5'd1, 5'd2, 5'd3, 8'h01, 32'h100);
        step();
        drive(5'd1, 5'd2, 5'd3, 8'h01, 32'h104);
        ext_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold pc", ex_pc, 32'h100);
        end
        ext_stall_i = 0;
        step();
        chk("release pc", ex_pc, 32'h104);

        // load to x0 then use of x0
        drive(5'd1, 5'd0, 5'd0, 8'h0B, 32'h108);
        step();
        drive(5'd0, 5'd0, 5'd4, 8'h01, 32'h10C);
        #1 chk("x0 no stall", 32'(stall_o), 0);
        step();

        // WB bypass on rs2
        drive(5'd1, 5'd3, 5'd4, 8'h01, 32'h110);
        id_rdata2 = 32'h11; wb_regwrite = 1; wb_rd = 5'd3; wb_wdata = 32'hDEADBEEF;
        step();
`ifdef IDEX_RF_BYPASS_EN
        chk("bypass rdata2", ex_rdata2, 32'hDEADBEEF);
`else
        chk("no bypass rdata2", ex_rdata2, 32'h11);
`endif
        wb_regwrite = 0;

        // drive counter into saturation
        for (int i = 0; i < 300; i++) begin
            drive(5'd1, 5'd0, 5'd5, 8'h02, 32'h200);
            step();
            drive(5'd0, 5'd5, 5'd6, 8'h01, 32'h204);
            step();
        end
        chk("cnt saturated", 32'(ldu_bubble_cnt), 32'(CNT_MAX));

        // async reset mid-cycle with a valid instruction in EX
        drive(5'd1, 5'd2, 5'd3, 8'h03, 32'h300);
        step();
        chk("pre-reset valid", 32'(ex_valid), 1);
        #1 rst = 1;
        #1;
        chk("async valid", 32'(ex_valid), 0);
        chk("async ctrl", 32'(ex_ctrl), 0);
        chk("async rd", 32'(ex_rd), 0);
        chk("async pc", ex_pc, 0);
        chk("async cnt", 32'(ldu_bubble_cnt), 0);
        @(negedge clk);
        #2 rst = 0;
        step();

        // randomized traffic with a small register space so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            id_valid    = ($urandom_range(0, 9) != 0);
            id_pc       = $urandom;
            id_rdata1   = $urandom;
            id_rdata2   = $urandom;
            id_imm      = $urandom;
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rd       = 5'($urandom_range(0, 3));
            id_funct    = 4'($urandom);
            id_ctrl     = CTRL_W'($urandom) | (($urandom_range(0, 1) != 0) ? 8'h02 : 8'h00);
            flush_i     = ($urandom_range(0, 9) == 0);
            ext_stall_i = ($urandom_range(0, 6) == 0);
            wb_regwrite = ($urandom_range(0, 1) != 0);
            wb_rd       = 5'($urandom_range(0, 3));
            wb_wdata    = $urandom;
            step();
        end

        idle();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
